// File: rtl/icache_rsp_pkg.sv
// Shared types for the icache refill responder: FSM state encoding, the
// response beat record held in the R-side FIFO, and the AXI response codes.
package icache_rsp_pkg;

    // Default widths of the packaged beat record; the top re-declares the
    // record with its own parameter widths and hands it to the FIFO.
    localparam int unsigned RSP_DATA_W = 64;
    localparam int unsigned RSP_ID_W   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } rsp_state_e;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic [RSP_ID_W-1:0]   id;
        logic                  last;
        logic [1:0]            resp;
    } rsp_beat_t;

    // Response code for a beat depending on whether its word was readable.
    function automatic logic [1:0] beat_resp(input logic in_range);
        return in_range ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/icache_refill_responder_if.sv
// AXI4 read-channel (AR + R) bundle between the icache refill master and the
// responder. The master modport drives AR and accepts R; slave is the reverse.
interface icache_refill_responder_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
) ();

    logic                 ar_valid_i;
    logic                 ar_ready_o;
    logic [AddrWidth-1:0] ar_addr_i;
    logic [7:0]           ar_len_i;
    logic [2:0]           ar_size_i;
    logic [IdWidth-1:0]   ar_id_i;

    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [DataWidth-1:0] r_data_o;
    logic [IdWidth-1:0]   r_id_o;
    logic                 r_last_o;
    logic [1:0]           r_resp_o;

    modport master (
        output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_id_i, r_ready_i,
        input  ar_ready_o, r_valid_o, r_data_o, r_id_o, r_last_o, r_resp_o
    );

    modport slave (
        input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_id_i, r_ready_i,
        output ar_ready_o, r_valid_o, r_data_o, r_id_o, r_last_o, r_resp_o
    );

endinterface

// File: rtl/icache_rsp_fifo.sv
// Small R-side output FIFO of response beats. The head entry is presented
// combinationally so a beat can leave the same cycle r_ready is seen; a push
// into a full FIFO is accepted only when a pop frees a slot in that cycle.
module icache_rsp_fifo
    import icache_rsp_pkg::*;
#(
    parameter int unsigned FifoDepth = 2,
    parameter type         beat_t    = rsp_beat_t
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  beat_t                          din_i,
    input  logic                           pop_i,
    output beat_t                          dout_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(FifoDepth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    beat_t           storage [FifoDepth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at FifoDepth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_reg == '0);
    assign full_o  = (count_reg == CntW'(FifoDepth));
    assign count_o = count_reg;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = storage[rd_ptr_reg];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Beat storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) storage[wr_ptr_reg] <= din_i;
    end

endmodule

// File: rtl/icache_refill_responder.sv
// AXI4 read responder for the L1I$ refill path. Accepts one AR at a time,
// walks the burst as INCR reads of a word-addressed backing store with a
// one-cycle read latency, and returns R beats through a small FIFO. A read is
// only issued when its beat is guaranteed a FIFO slot, so R backpressure never
// drops data.
// Optional build macro: ICACHE_RSP_RANGE_CHECK_EN -- beats whose word address
// is beyond the store are not read and return zero data with DECERR; without
// it addresses wrap modulo MemWords and every beat is OKAY.
module icache_refill_responder
    import icache_rsp_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned MemWords  = 1024,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    icache_refill_responder_if.slave    bus,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [DataWidth-1:0]        mem_rdata_i
);

    localparam int unsigned OffW = $clog2(DataWidth / 8);
    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 last;
        logic [1:0]           resp;
    } beat_t;

    rsp_state_e           state_reg;
    logic [AddrWidth-1:0] cur_addr_reg;
    logic [7:0]           len_reg;
    logic [7:0]           cnt_reg;
    logic [2:0]           size_reg;
    logic [IdWidth-1:0]   id_reg;
    logic                 inflight_reg;
    logic                 pend_last_reg;
    logic [1:0]           pend_resp_reg;

    logic                 ar_ready;
    logic                 ar_hs;
    logic                 r_valid;
    logic                 r_pop;
    logic                 issue;
    logic                 in_range;
    logic                 drain_done;
    logic [31:0]          pending;
    beat_t                push_beat;
    beat_t                head_beat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CntW-1:0]      fifo_count;

    assign ar_ready = (state_reg == IDLE) & ~rst_i;
    assign ar_hs    = bus.ar_valid_i & ar_ready;
    assign r_valid  = ~fifo_empty & ~rst_i;
    assign r_pop    = r_valid & bus.r_ready_i;

    // Slots committed after this cycle: buffered beats plus the read in
    // flight, less the beat leaving now. Counting the pop keeps one beat per
    // cycle flowing with only two FIFO entries.
    assign pending    = 32'(fifo_count) + 32'(inflight_reg) - 32'(r_pop);
    assign issue      = (state_reg == BURST) & (pending < FifoDepth) & ~rst_i;
    assign drain_done = ~inflight_reg & (fifo_empty | ((fifo_count == CntW'(1)) & r_pop));

`ifdef ICACHE_RSP_RANGE_CHECK_EN
    logic [AddrWidth-1:0] word_addr;
    assign word_addr = cur_addr_reg >> OffW;
    assign in_range  = (word_addr < AddrWidth'(MemWords));
`else
    assign in_range = 1'b1;
`endif

    // Out-of-range beats still occupy a slot but never touch the store.
    assign mem_req_o  = issue & in_range;
    assign mem_addr_o = cur_addr_reg[OffW +: IdxW];

    assign push_beat.data = (pend_resp_reg == RESP_OKAY) ? mem_rdata_i : '0;
    assign push_beat.id   = id_reg;
    assign push_beat.last = pend_last_reg;
    assign push_beat.resp = pend_resp_reg;

    icache_rsp_fifo #(
        .FifoDepth (FifoDepth),
        .beat_t    (beat_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_reg),
        .din_i   (push_beat),
        .pop_i   (r_pop),
        .dout_o  (head_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.ar_ready_o = ar_ready;
    assign bus.r_valid_o  = r_valid;
    assign bus.r_data_o   = r_valid ? head_beat.data : '0;
    assign bus.r_id_o     = r_valid ? head_beat.id   : '0;
    assign bus.r_last_o   = r_valid ? head_beat.last : 1'b0;
    assign bus.r_resp_o   = r_valid ? head_beat.resp : RESP_OKAY;

    // Burst sequencer plus the one-cycle read pipeline stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            size_reg      <= '0;
            id_reg        <= '0;
            inflight_reg  <= 1'b0;
            pend_last_reg <= 1'b0;
            pend_resp_reg <= RESP_OKAY;
        end else begin
            inflight_reg  <= issue;
            pend_last_reg <= (cnt_reg == len_reg);
            pend_resp_reg <= beat_resp(in_range);
            case (state_reg)
                IDLE: begin
                    if (ar_hs) begin
                        cur_addr_reg <= bus.ar_addr_i;
                        len_reg      <= bus.ar_len_i;
                        size_reg     <= bus.ar_size_i;
                        id_reg       <= bus.ar_id_i;
                        cnt_reg      <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        cur_addr_reg <= cur_addr_reg + (AddrWidth'(1) << size_reg);
                        cnt_reg      <= cnt_reg + 8'd1;
                        if (cnt_reg == len_reg) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        ar_hs |-> (bus.ar_size_i <= 3'(OffW)));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (inflight_reg && fifo_full) |-> r_pop);

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder: a registered backing-store model
// answers every mem_req_o one cycle later with a known pattern per word, and
// each scenario task checks the returned R beats inline.
`timescale 1ns/1ps
module tb_icache_refill_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [63:0] mem_rdata = '0;

    int n_total = 0;
    int n_bad   = 0;

    int outstanding = 0;
    int max_out     = 0;

    logic [63:0] got_data[$];
    logic [3:0]  got_id[$];
    logic        got_last[$];
    logic [1:0]  got_resp[$];
    int          first_k;
    logic        ar_ready_after;

    always #5 clk = ~clk;

    icache_refill_responder_if #(.AddrWidth(64), .DataWidth(64), .IdWidth(4)) bus ();

    icache_refill_responder #(
        .AddrWidth (64),
        .DataWidth (64),
        .IdWidth   (4),
        .MemWords  (1024),
        .FifoDepth (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [63:0] memval(input int w);
        return 64'hD00D_0000_0000_0000 | 64'(w);
    endfunction

    logic [9:0] issued_q[$];

    // Backing store: data for the requested word appears one cycle later.
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= memval(int'(mem_addr));
            issued_q.push_back(mem_addr);
        end
    end

    // Beats issued but not yet handed over on R.
    always @(posedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(mem_req) - int'(bus.r_valid_o && bus.r_ready_i);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic send_ar(input logic [63:0] a, input int l, input int s, input int id);
        int n = 0;
        bus.ar_addr_i  = a;
        bus.ar_len_i   = 8'(l);
        bus.ar_size_i  = 3'(s);
        bus.ar_id_i    = 4'(id);
        bus.ar_valid_i = 1'b1;
        while (!bus.ar_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (bus.ar_ready_o !== 1'b1) begin
            $display("FAIL ar_accept addr=%h got ar_ready=%b exp=1", a, bus.ar_ready_o);
            n_bad++;
        end
        @(posedge clk); #1;
        bus.ar_valid_i = 1'b0;
    endtask

    // Gathers n_exp beats with r_ready held high; k counts cycles after the AR handshake.
    task automatic collect(input int n_exp);
        got_data.delete(); got_id.delete(); got_last.delete(); got_resp.delete();
        first_k = -1;
        bus.r_ready_i = 1'b1;
        for (int k = 0; k < 600 && got_data.size() < n_exp; k++) begin
            if (bus.r_valid_o) begin
                if (first_k < 0) first_k = k;
                got_data.push_back(bus.r_data_o);
                got_id.push_back(bus.r_id_o);
                got_last.push_back(bus.r_last_o);
                got_resp.push_back(bus.r_resp_o);
            end
            @(posedge clk); #1;
        end
        ar_ready_after = bus.ar_ready_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus.ar_ready_o !== 1'b0 || bus.r_valid_o !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL reset_ctl got ar_ready=%b r_valid=%b mem_req=%b exp=0/0/0",
                     bus.ar_ready_o, bus.r_valid_o, mem_req);
            n_bad++;
        end
        n_total++;
        if (bus.r_data_o !== 64'h0 || bus.r_id_o !== 4'h0 || bus.r_last_o !== 1'b0 || bus.r_resp_o !== 2'b00) begin
            $display("FAIL reset_data got data=%h id=%h last=%b resp=%b exp=all zero",
                     bus.r_data_o, bus.r_id_o, bus.r_last_o, bus.r_resp_o);
            n_bad++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (bus.ar_ready_o !== 1'b1) begin
            $display("FAIL reset_release got ar_ready=%b exp=1", bus.ar_ready_o);
            n_bad++;
        end
        $display("test_reset done");
    endtask

    task automatic test_burst4();
        issued_q.delete();
        send_ar(64'h40, 3, 3, 5);
        collect(4);
        n_total++;
        if (got_data.size() != 4) begin
            $display("FAIL t1_count got=%0d exp=4", got_data.size());
            n_bad++;
        end
        n_total++;
        if (first_k != 2) begin
            $display("FAIL t1_latency got=%0d exp=2", first_k);
            n_bad++;
        end
        n_total++;
        if (ar_ready_after !== 1'b1) begin
            $display("FAIL t1_ar_ready_after got=%b exp=1", ar_ready_after);
            n_bad++;
        end
        n_total++;
        if (issued_q.size() != 4) begin
            $display("FAIL t1_issue_count got=%0d exp=4", issued_q.size());
            n_bad++;
        end
        for (int i = 0; i < got_data.size() && i < issued_q.size(); i++) begin
            n_total++;
            if (issued_q[i] !== 10'(8 + i)) begin
                $display("FAIL t1_mem_addr[%0d] got=%0d exp=%0d", i, issued_q[i], 8 + i);
                n_bad++;
            end
            n_total++;
            if (got_data[i] !== memval(8 + i) || got_id[i] !== 4'd5 ||
                got_last[i] !== (i == 3) || got_resp[i] !== 2'b00) begin
                $display("FAIL t1_beat[%0d] got data=%h id=%0d last=%b resp=%b exp data=%h id=5 last=%b resp=0",
                         i, got_data[i], got_id[i], got_last[i], got_resp[i], memval(8 + i), (i == 3));
                n_bad++;
            end
        end
        $display("test_burst4 done beats=%0d latency=%0d", got_data.size(), first_k);
    endtask

    task automatic test_single();
        send_ar(64'h18, 0, 3, 2);
        collect(1);
        n_total++;
        if (got_data.size() != 1 || got_data[0] !== 64'hD00D_0000_0000_0003 || got_id[0] !== 4'd2 ||
            got_last[0] !== 1'b1 || got_resp[0] !== 2'b00) begin
            $display("FAIL t2_single got n=%0d data=%h id=%0d last=%b resp=%b exp n=1 data=d00d000000000003 id=2 last=1 resp=0",
                     got_data.size(), got_data.size() ? got_data[0] : 64'h0,
                     got_data.size() ? got_id[0] : 4'h0, got_data.size() ? got_last[0] : 1'b0,
                     got_data.size() ? got_resp[0] : 2'b00);
            n_bad++;
        end
        $display("test_single done data=%h", got_data.size() ? got_data[0] : 64'h0);
    endtask

    task automatic test_narrow();
        // 4-byte beats from 0x8: byte addresses 8,12,16,20 -> words 1,1,2,2
        send_ar(64'h8, 3, 2, 10);
        collect(4);
        n_total++;
        if (got_data.size() != 4) begin
            $display("FAIL t_narrow_count got=%0d exp=4", got_data.size());
            n_bad++;
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_total++;
            if (got_data[i] !== memval(1 + i / 2) || got_id[i] !== 4'd10 || got_last[i] !== (i == 3)) begin
                $display("FAIL t_narrow[%0d] got data=%h id=%0d last=%b exp data=%h id=10 last=%b",
                         i, got_data[i], got_id[i], got_last[i], memval(1 + i / 2), (i == 3));
                n_bad++;
            end
        end
        $display("test_narrow done beats=%0d", got_data.size());
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        logic        stalled = 1'b0;
        int          nb = 0;
        max_out = 0;
        got_data.delete(); got_last.delete(); got_id.delete();
        send_ar(64'h100, 7, 3, 7);
        for (int i = 0; i < 400 && nb < 8; i++) begin
            if (stalled) begin
                n_total++;
                if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== held) begin
                    $display("FAIL t3_stall_hold cyc=%0d got valid=%b data=%h exp valid=1 data=%h",
                             i, bus.r_valid_o, bus.r_data_o, held);
                    n_bad++;
                end
            end
            bus.r_ready_i = ((i % 3) == 0);
            stalled = bus.r_valid_o && !bus.r_ready_i;
            held    = bus.r_data_o;
            if (bus.r_valid_o && bus.r_ready_i) begin
                got_data.push_back(bus.r_data_o);
                got_id.push_back(bus.r_id_o);
                got_last.push_back(bus.r_last_o);
                nb++;
            end
            @(posedge clk); #1;
        end
        bus.r_ready_i = 1'b1;
        n_total++;
        if (nb != 8) begin
            $display("FAIL t3_count got=%0d exp=8", nb);
            n_bad++;
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_total++;
            if (got_data[i] !== memval(32 + i) || got_id[i] !== 4'd7 || got_last[i] !== (i == 7)) begin
                $display("FAIL t3_beat[%0d] got data=%h id=%0d last=%b exp data=%h id=7 last=%b",
                         i, got_data[i], got_id[i], got_last[i], memval(32 + i), (i == 7));
                n_bad++;
            end
        end
        n_total++;
        if (max_out > 2) begin
            $display("FAIL t3_max_pending got=%0d exp<=2", max_out);
            n_bad++;
        end
        $display("test_backpressure done beats=%0d max_pending=%0d", nb, max_out);
    endtask

    task automatic test_back_to_back();
        int   nb = 0;
        int   early = 0;
        logic hs;
        got_data.delete(); got_id.delete(); got_last.delete();
        send_ar(64'h200, 3, 3, 1);
        bus.ar_addr_i  = 64'h300;
        bus.ar_len_i   = 8'd1;
        bus.ar_size_i  = 3'd3;
        bus.ar_id_i    = 4'd9;
        bus.ar_valid_i = 1'b1;
        bus.r_ready_i  = 1'b1;
        for (int i = 0; i < 200 && nb < 6; i++) begin
            hs = bus.ar_valid_i && bus.ar_ready_o;
            if (bus.ar_ready_o && nb < 4) early++;
            if (bus.r_valid_o) begin
                got_data.push_back(bus.r_data_o);
                got_id.push_back(bus.r_id_o);
                got_last.push_back(bus.r_last_o);
                nb++;
            end
            @(posedge clk); #1;
            if (hs) bus.ar_valid_i = 1'b0;
        end
        bus.ar_valid_i = 1'b0;
        n_total++;
        if (early != 0) begin
            $display("FAIL t4_ar_ready_during_burst got=%0d cycles exp=0", early);
            n_bad++;
        end
        n_total++;
        if (nb != 6) begin
            $display("FAIL t4_count got=%0d exp=6", nb);
            n_bad++;
        end
        for (int i = 0; i < got_data.size(); i++) begin
            automatic int          w  = (i < 4) ? 64 + i : 96 + (i - 4);
            automatic logic [3:0]  id = (i < 4) ? 4'd1 : 4'd9;
            automatic logic        ls = (i == 3) || (i == 5);
            n_total++;
            if (got_data[i] !== memval(w) || got_id[i] !== id || got_last[i] !== ls) begin
                $display("FAIL t4_beat[%0d] got data=%h id=%0d last=%b exp data=%h id=%0d last=%b",
                         i, got_data[i], got_id[i], got_last[i], memval(w), id, ls);
                n_bad++;
            end
        end
        $display("test_back_to_back done beats=%0d", nb);
    endtask

    task automatic test_reset_mid_burst();
        int nb = 0;
        int stray = 0;
        send_ar(64'h0, 7, 3, 3);
        bus.r_ready_i = 1'b1;
        for (int i = 0; i < 100 && nb < 2; i++) begin
            if (bus.r_valid_o) nb++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (bus.r_valid_o !== 1'b0 || bus.ar_ready_o !== 1'b0 || bus.r_data_o !== 64'h0) begin
            $display("FAIL t5_in_reset got r_valid=%b ar_ready=%b data=%h exp 0/0/0",
                     bus.r_valid_o, bus.ar_ready_o, bus.r_data_o);
            n_bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (bus.ar_ready_o !== 1'b1) begin
            $display("FAIL t5_after_release got ar_ready=%b exp=1", bus.ar_ready_o);
            n_bad++;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.r_valid_o || mem_req) stray++;
            @(posedge clk); #1;
        end
        n_total++;
        if (stray != 0) begin
            $display("FAIL t5_stray_activity got=%0d cycles exp=0", stray);
            n_bad++;
        end
        send_ar(64'h80, 1, 3, 4);
        collect(2);
        n_total++;
        if (got_data.size() != 2 || got_data[0] !== memval(16) || got_data[1] !== memval(17) ||
            got_id[0] !== 4'd4 || got_id[1] !== 4'd4 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            $display("FAIL t5_clean_burst got n=%0d exp n=2 data=%h,%h id=4 last=0,1",
                     got_data.size(), memval(16), memval(17));
            n_bad++;
        end
        $display("test_reset_mid_burst done beats_before_reset=%0d", nb);
    endtask

    task automatic test_range();
        send_ar(64'h1FF8, 1, 3, 6);
        collect(2);
        n_total++;
        if (got_data.size() != 2) begin
            $display("FAIL t6_count got=%0d exp=2", got_data.size());
            n_bad++;
        end else begin
            n_total++;
            if (got_data[0] !== memval(1023) || got_resp[0] !== 2'b00 || got_last[0] !== 1'b0 || got_id[0] !== 4'd6) begin
                $display("FAIL t6_beat0 got data=%h resp=%b last=%b id=%0d exp data=%h resp=0 last=0 id=6",
                         got_data[0], got_resp[0], got_last[0], got_id[0], memval(1023));
                n_bad++;
            end
`ifdef ICACHE_RSP_RANGE_CHECK_EN
            n_total++;
            if (got_data[1] !== 64'h0 || got_resp[1] !== 2'b11 || got_last[1] !== 1'b1) begin
                $display("FAIL t6_beat1 got data=%h resp=%b last=%b exp data=0 resp=11 last=1",
                         got_data[1], got_resp[1], got_last[1]);
                n_bad++;
            end
`else
            n_total++;
            if (got_data[1] !== memval(0) || got_resp[1] !== 2'b00 || got_last[1] !== 1'b1) begin
                $display("FAIL t6_beat1 got data=%h resp=%b last=%b exp data=%h resp=0 last=1",
                         got_data[1], got_resp[1], got_last[1], memval(0));
                n_bad++;
            end
`endif
        end
        $display("test_range done beats=%0d", got_data.size());
    endtask

    initial begin
        bus.ar_valid_i = 1'b0;
        bus.ar_addr_i  = '0;
        bus.ar_len_i   = '0;
        bus.ar_size_i  = '0;
        bus.ar_id_i    = '0;
        bus.r_ready_i  = 1'b0;
        test_reset();
        test_burst4();
        test_single();
        test_narrow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_range();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
